product_sign_correct_pipe: RTL and testbench

- Output stage directly downstream of the Vedic (Urdhva-Tiryakbhyam) magnitude core, which is fed by the operand two's-complement stage.
- Takes the unsigned magnitude product and the per-byte sign flags produced upstream for operands A and B.
- Restores the signed product per lane by segmented two's complement according to precision, then selects the low or high half per opcode.
- Two-stage valid/ready pipeline that fully decouples the multiplier core from the vector writeback.

---
 rtl/product_sign_correct_pipe_if.sv | 27 ++
 rtl/product_sign_correct_pipe.sv | 123 ++++++++++++
 tb/tb_product_sign_correct_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/product_sign_correct_pipe_if.sv
// Handshake bundle between the Vedic magnitude core and the vector writeback.
// Input side: in_valid/in_ready, product, sign_a, sign_b, opcode and precision.
// Output side: out_valid/out_ready and result. master drives inputs; slave is the pipe.
interface product_sign_correct_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*WIDTH-1:0]   product;
    logic [3:0]           sign_a;
    logic [3:0]           sign_b;
    logic [1:0]           opcode;
    logic [1:0]           precision;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*WIDTH-1:0]   result;

    modport master (
        output in_valid, product, sign_a, sign_b, opcode, precision, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, product, sign_a, sign_b, opcode, precision, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/product_sign_correct_pipe.sv
// Restores the signed product per lane (segmented two's complement) and picks the low/high half.
// Latency 2 cycles from input transfer to out_valid; throughput 1 result per cycle.
// Backpressure: stage 2 holds while out_ready=0, stage 1 then fills and in_ready drops.
// Ports: clk, rst_n (async active-low); bus (slave): in_valid/in_ready + product, sign_a,
//        sign_b, opcode, precision in; out_valid/out_ready + result out.
module product_sign_correct_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    product_sign_correct_pipe_if.slave    bus
);
    localparam int LW8  = 2 * WIDTH;   // product lane width at 8-bit precision
    localparam int LW16 = 4 * WIDTH;   // product lane width at 16-bit precision
    localparam int PW   = 8 * WIDTH;   // full product width
    localparam int RW   = 4 * WIDTH;   // result width

    typedef struct packed {
        logic [PW-1:0] prod;
        logic [1:0]    opcode;
        logic [1:0]    precision;
    } s1_t;

    s1_t           s1_dat;
    s1_t           s1_nxt;
    logic          s1_valid;
    logic          s2_valid;
    logic [RW-1:0] s2_result;
    logic [RW-1:0] sel_result;
    logic          s1_advance;
    logic          in_rdy;
    logic [3:0]    neg_byte;
    logic [PW-1:0] corr_8;
    logic [PW-1:0] corr_16;
    logic [PW-1:0] corr_32;
    logic          sel_hi;

    assign s1_advance    = !s2_valid || bus.out_ready;
    assign in_rdy        = !s1_valid || s1_advance;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;

    // Per-byte negate flags; each precision reads the flag of its lane's most significant byte.
    assign neg_byte = bus.sign_a ^ bus.sign_b;

    // All three segmentations are built in parallel; unary minus at the lane width drops
    // the carry out of the lane, so a zero magnitude stays zero and lanes never interact.
    always_comb begin
        corr_8  = '0;
        corr_16 = '0;
        for (int i = 0; i < 4; i++) begin
            corr_8[LW8*i +: LW8] = neg_byte[i] ? -bus.product[LW8*i +: LW8]
                                               :  bus.product[LW8*i +: LW8];
        end
        for (int j = 0; j < 2; j++) begin
            corr_16[LW16*j +: LW16] = neg_byte[2*j+1] ? -bus.product[LW16*j +: LW16]
                                                      :  bus.product[LW16*j +: LW16];
        end
        corr_32 = neg_byte[3] ? -bus.product : bus.product;
    end

    always_comb begin
        s1_nxt           = '0;
        s1_nxt.opcode    = bus.opcode;
        s1_nxt.precision = bus.precision;
        case (bus.precision)
            2'b01:   s1_nxt.prod = corr_16;
            2'b10:   s1_nxt.prod = corr_32;
            default: s1_nxt.prod = corr_8;   // 00 and the reserved 11 both mean 8-bit
        endcase
    end

    // Stage 2 half select: only MUL keeps the low half; every other opcode wants the high half.
    assign sel_hi = (s1_dat.opcode != 2'b00);

    always_comb begin
        sel_result = '0;
        case (s1_dat.precision)
            2'b01: begin
                for (int j = 0; j < 2; j++) begin
                    sel_result[LW8*j +: LW8] = sel_hi ? s1_dat.prod[LW16*j+LW8 +: LW8]
                                                      : s1_dat.prod[LW16*j +: LW8];
                end
            end
            2'b10: begin
                sel_result = sel_hi ? s1_dat.prod[PW-1:RW] : s1_dat.prod[RW-1:0];
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    sel_result[WIDTH*i +: WIDTH] = sel_hi ? s1_dat.prod[LW8*i+WIDTH +: WIDTH]
                                                          : s1_dat.prod[LW8*i +: WIDTH];
                end
            end
        endcase
    end

    // Stage 1: load only on an input transfer; valid follows in_valid whenever the slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dat   <= '0;
        end else if (in_rdy) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_dat <= s1_nxt;
            end
        end
    end

    // Stage 2: result only changes when a new s1 entry moves in, so it is stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= sel_result;
            end
        end
    end
endmodule

// File: tb/tb_product_sign_correct_pipe.sv
module tb_product_sign_correct_pipe;
    logic clk;
    logic rst_n;

    product_sign_correct_pipe_if #(.WIDTH(8)) bus_if ();

    product_sign_correct_pipe #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] product;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [1:0]  op;
        logic [1:0]  prec;
        logic [31:0] exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 0;
    bit          hold_prev = 0;
    logic [31:0] held_result;
    logic [31:0] exp_q[$];
    vec_t        vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each lane is a number modulo 2^lane_width; negate it there, then take a half.
    function automatic logic [31:0] model(input logic [63:0] p, input logic [3:0] sa,
                                          input logic [3:0] sb, input logic [1:0] op,
                                          input logic [1:0] prec);
        int          lw, nl, half, k;
        logic [63:0] mask, mag, val;
        logic [31:0] r;
        case (prec)
            2'b01:   lw = 32;
            2'b10:   lw = 64;
            default: lw = 16;
        endcase
        nl   = 64 / lw;
        half = lw / 2;
        mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
        r    = '0;
        for (int l = 0; l < nl; l++) begin
            k   = (l + 1) * (4 / nl) - 1;
            mag = (p >> (l * lw)) & mask;
            val = (sa[k] ^ sb[k]) ? ((64'd0 - mag) & mask) : mag;
            if (op != 2'b00) val = val >> half;
            val = val & ((64'd1 << half) - 64'd1);
            r   = r | (32'(val) << (l * half));
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bus_if.product   = v.product;
        bus_if.sign_a    = v.sa;
        bus_if.sign_b    = v.sb;
        bus_if.opcode    = v.op;
        bus_if.precision = v.prec;
        bus_if.in_valid  = 1'b1;
    endtask

    // One isolated transaction into an empty pipe: checks acceptance, 2-cycle latency and value.
    task automatic send_one(input vec_t v, input string name);
        @(posedge clk); #1;
        drive(v);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk({name, " in_ready"}, 64'(bus_if.in_ready), 64'd1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.product  = {$urandom, $urandom};
        bus_if.sign_a   = 4'($urandom);
        @(negedge clk);
        chk({name, " lat1 out_valid"}, 64'(bus_if.out_valid), 64'd0);
        @(negedge clk);
        chk({name, " out_valid"}, 64'(bus_if.out_valid), 64'd1);
        chk({name, " result"}, 64'(bus_if.result), 64'(v.exp));
    endtask

    function automatic vec_t rand_vec(input logic [1:0] prec);
        vec_t v;
        v.product = {$urandom, $urandom};
        v.sa      = 4'($urandom);
        v.op      = 2'($urandom);
        v.sb      = (v.op[1]) ? 4'b0000 : 4'($urandom);
        v.prec    = prec;
        v.exp     = model(v.product, v.sa, v.sb, v.op, v.prec);
        return v;
    endfunction

    // Scoreboard for free-running traffic: inputs seen at negedge transfer on the next edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (hold_prev) begin
                chk("hold out_valid", 64'(bus_if.out_valid), 64'd1);
                chk("hold result", 64'(bus_if.result), 64'(held_result));
            end
            if (bus_if.in_valid && bus_if.in_ready)
                exp_q.push_back(model(bus_if.product, bus_if.sign_a, bus_if.sign_b,
                                      bus_if.opcode, bus_if.precision));
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand unexpected output: got %h expected none", bus_if.result);
                end else begin
                    chk("rand result", 64'(bus_if.result), 64'(exp_q.pop_front()));
                end
            end
            hold_prev   = bus_if.out_valid && !bus_if.out_ready;
            held_result = bus_if.result;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        vec_t a, b, c, d;
        vecs[0]  = '{64'h000F, 4'b0001, 4'b0000, 2'b00, 2'b00, 32'h0000_00F1};
        vecs[1]  = '{64'h000F, 4'b0001, 4'b0000, 2'b01, 2'b00, 32'h0000_00FF};
        vecs[2]  = '{64'h000F, 4'b0001, 4'b0000, 2'b00, 2'b11, 32'h0000_00F1};
        vecs[3]  = '{64'h000F, 4'b0001, 4'b0000, 2'b01, 2'b11, 32'h0000_00FF};
        vecs[4]  = '{64'h0001, 4'b1111, 4'b1111, 2'b00, 2'b10, 32'h0000_0001};
        vecs[5]  = '{64'h0001, 4'b1111, 4'b1111, 2'b01, 2'b10, 32'h0000_0000};
        vecs[6]  = '{64'h0000_0000_FFFE_0001, 4'b0000, 4'b0000, 2'b10, 2'b01, 32'h0000_FFFE};
        vecs[7]  = '{64'h0000, 4'b1111, 4'b0000, 2'b00, 2'b00, 32'h0000_0000};
        vecs[8]  = '{64'h0000, 4'b1111, 4'b0000, 2'b01, 2'b00, 32'h0000_0000};
        vecs[9]  = '{64'h0000_0001_0000_0006, 4'b1010, 4'b1000, 2'b00, 2'b01, 32'h0001_FFFA};
        vecs[10] = '{64'h0000_0001_0000_0006, 4'b1010, 4'b1000, 2'b11, 2'b01, 32'h0000_FFFF};
        vecs[11] = '{64'h0006, 4'b1000, 4'b0000, 2'b00, 2'b10, 32'hFFFF_FFFA};
        vecs[12] = '{64'h0100_0002_00FF_0010, 4'b0101, 4'b0011, 2'b00, 2'b00, 32'h00FE_0110};
        vecs[13] = '{64'h0100_0002_00FF_0010, 4'b0101, 4'b0011, 2'b01, 2'b00, 32'h01FF_FF00};
        vecs[14] = '{64'h0006, 4'b0001, 4'b0000, 2'b00, 2'b01, 32'h0000_0006};
        vecs[15] = '{64'h0006, 4'b0111, 4'b0000, 2'b00, 2'b10, 32'h0000_0006};

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.product   = '0;
        bus_if.sign_a    = '0;
        bus_if.sign_b    = '0;
        bus_if.opcode    = '0;
        bus_if.precision = '0;
        #12;
        chk("reset out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("reset result", 64'(bus_if.result), 64'd0);
        chk("reset in_ready", 64'(bus_if.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) send_one(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: four back-to-back inputs, out_ready low for five cycles.
        a = rand_vec(2'b00); b = rand_vec(2'b01); c = rand_vec(2'b10); d = rand_vec(2'b11);
        @(posedge clk); #1;
        drive(a);
        bus_if.out_ready = 1'b0;
        @(negedge clk); chk("bp accept a", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk); #1; drive(b);
        @(negedge clk); chk("bp accept b", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk); #1; drive(c);
        for (int cy = 0; cy < 3; cy++) begin
            @(negedge clk);
            chk("bp stall in_ready", 64'(bus_if.in_ready), 64'd0);
            chk("bp stall out_valid", 64'(bus_if.out_valid), 64'd1);
            chk("bp stall result", 64'(bus_if.result), 64'(a.exp));
            @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp accept c", 64'(bus_if.in_ready), 64'd1);
        chk("bp out a", 64'(bus_if.result), 64'(a.exp));
        @(posedge clk); #1; drive(d);
        @(negedge clk);
        chk("bp accept d", 64'(bus_if.in_ready), 64'd1);
        chk("bp out_valid b", 64'(bus_if.out_valid), 64'd1);
        chk("bp out b", 64'(bus_if.result), 64'(b.exp));
        @(posedge clk); #1; bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("bp out_valid c", 64'(bus_if.out_valid), 64'd1);
        chk("bp out c", 64'(bus_if.result), 64'(c.exp));
        @(negedge clk);
        chk("bp out_valid d", 64'(bus_if.out_valid), 64'd1);
        chk("bp out d", 64'(bus_if.result), 64'(d.exp));
        @(negedge clk);
        chk("bp drained", 64'(bus_if.out_valid), 64'd0);

        // Reset with both stages full: outputs clear asynchronously, nothing leaks afterwards.
        a = rand_vec(2'b00); b = rand_vec(2'b00);
        a.product[15:0] = 16'h1234;
        @(posedge clk); #1; drive(a); bus_if.out_ready = 1'b0;
        @(posedge clk); #1; drive(b);
        @(posedge clk); #1; bus_if.in_valid = 1'b0;
        @(negedge clk); chk("rst pre out_valid", 64'(bus_if.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst async result", 64'(bus_if.result), 64'd0);
        chk("rst async in_ready", 64'(bus_if.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_one(vecs[12], "post reset");
        @(negedge clk);
        chk("post reset drained", 64'(bus_if.out_valid), 64'd0);

        // Random traffic against the scoreboard, random stalls on both sides.
        mon_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            drive(rand_vec(2'($urandom)));
            bus_if.in_valid  = ($urandom_range(0, 2) != 0);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("rand queue empty", 64'(exp_q.size()), 64'd0);
        chk("rand final out_valid", 64'(bus_if.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
